// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: an instruction-fetch port and a data port share
// one single-port memory. Ties are broken round-robin, every transfer is bounded
// by a timeout, and completion is signalled with a one-cycle ack (plus bus_err on
// timeout).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wd,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_d;   // 1: the most recent grant went to the data port
  logic        r_gnt_d;    // 1: the transfer in flight belongs to the data port
  logic [7:0]  r_cnt;      // BUSY cycles already spent without mem_ack
  logic        w_grant;
  logic        w_grant_d;
  logic        w_timeout;

  // Next-state and grant decision; data wins a tie only if fetch was granted last
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (if_req || d_req) begin
          w_grant   = 1'b1;
          w_grant_d = d_req && (!if_req || !r_last_d);
          w_next    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          w_next = RESP;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant bookkeeping and the registered memory-side request
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_d <= 1'b1;
      r_gnt_d  <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
    end else begin
      // mem_req is high exactly for the cycles spent in BUSY
      mem_req <= (w_next == BUSY);
      if (w_grant) begin
        r_last_d <= w_grant_d;
        r_gnt_d  <= w_grant_d;
        mem_addr <= w_grant_d ? d_addr : if_addr;
        mem_we   <= w_grant_d & d_we;
        mem_wd   <= w_grant_d ? d_wd : 32'd0;
      end
    end
  end

  // BUSY cycle counter, response capture and one-cycle ack/bus_err pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= 8'd0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      bus_err  <= 1'b0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      if_ack  <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      if (w_grant) begin
        r_cnt <= 8'd0;
      end else if (r_state == BUSY) begin
        if (mem_ack) begin
          if (r_gnt_d) begin
            d_ack   <= 1'b1;
            d_rdata <= mem_rdata;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end else if (w_timeout) begin
          bus_err <= 1'b1;
          if (r_gnt_d) begin
            d_ack   <= 1'b1;
            d_rdata <= 32'd0;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= 32'd0;
          end
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected acks, a negedge
// monitor pops and compares them, and a memory responder answers mem_req.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic              clock = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wd;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              bus_err;

  mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;

  // Responder controls
  int          resp_lat      = -1;   // BUSY cycle index carrying mem_ack; -1 = never
  logic [31:0] resp_data     = 32'd0;
  bit          resp_use_addr = 1'b0; // answer with mem_addr ^ KEY
  bit          ack_force     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: counts BUSY cycles and raises mem_ack on the chosen one
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clock);
      #2;
      if (mem_req) begin
        mem_ack   = (busy_cnt == resp_lat) || ack_force;
        mem_rdata = resp_use_addr ? (mem_addr ^ KEY) : resp_data;
        busy_cnt++;
      end else begin
        mem_ack   = ack_force;
        mem_rdata = resp_data;
        busy_cnt  = 0;
      end
    end
  end

  // Monitor: every ack is compared against the oldest expected response
  always @(negedge clock) begin
    exp_t e;
    if (if_ack || d_ack) begin
      check("ack_exclusive", 32'(if_ack && d_ack), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({if_ack, d_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port_is_data", 32'(d_ack), 32'(e.is_d));
        check("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
        check("ack_bus_err", 32'(bus_err), 32'(e.err));
      end
    end else if (bus_err) begin
      check("bus_err_without_ack", 32'(bus_err), 32'd0);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One request; checks the memory-side fields each BUSY cycle and the timing
  task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, input logic [31:0] rdata,
                        input logic [31:0] exp_rdata, input bit exp_err,
                        input int exp_lat, input int exp_busy);
    int   cyc;
    int   busy;
    bit   got;
    exp_t e;
    resp_lat      = lat;
    resp_data     = rdata;
    resp_use_addr = 1'b0;
    e.is_d  = is_d;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wd = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    cyc = 0; busy = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if (mem_req) begin
        busy++;
        check("mem_addr", mem_addr, addr);
        check("mem_we", 32'(mem_we), 32'(is_d & we));
        check("mem_wd", mem_wd, is_d ? wd : 32'd0);
      end
      got = is_d ? d_ack : if_ack;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    check("ack_latency", cyc, exp_lat);
    check("mem_req_cycles", busy, exp_busy);
    idle(2);
  endtask

  initial begin
    int n_ack;
    int cyc;
    exp_t e;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = 32'd0;

    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_acks", 32'({if_ack, d_ack, bus_err}), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    @(posedge clock);
    #1;

    // Single fetch, mem_ack one cycle after mem_req
    do_req(1'b0, 1'b0, 32'h40, 32'd0, 1, 32'h2002_000A, 32'h2002_000A, 1'b0, 3, 2);
    check("if_rdata_hold", if_rdata, 32'h2002_000A);

    // Store with immediate mem_ack; d_rdata takes mem_rdata as-is
    do_req(1'b1, 1'b1, 32'h54, 32'd7, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2, 1);

    // Load with three wait cycles
    do_req(1'b1, 1'b0, 32'h1234, 32'd0, 3, 32'h0000_55AA, 32'h0000_55AA, 1'b0, 5, 4);
    check("d_rdata_hold", d_rdata, 32'h0000_55AA);

    // Timeout: no mem_ack at all
    do_req(1'b1, 1'b0, 32'h80, 32'd0, -1, 32'h1111_1111, 32'd0, 1'b1, 16, 15);

    // mem_ack in the very last BUSY cycle still completes normally
    do_req(1'b1, 1'b0, 32'h88, 32'd0, 14, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 16, 15);

    // Reset in the second BUSY cycle, then a stray mem_ack
    resp_lat  = -1;
    resp_data = 32'hFFFF_0000;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
    idle(2);
    check("midbusy_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    d_req = 1'b0;
    @(posedge clock);
    #1;
    check("after_reset_mem_req", 32'(mem_req), 32'd0);
    reset     = 1'b0;
    ack_force = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
      check("no_ack_after_reset", 32'({if_ack, d_ack}), 32'd0);
    end
    ack_force = 1'b0;
    check("after_reset_d_rdata", d_rdata, 32'd0);
    check("after_reset_mem_req2", 32'(mem_req), 32'd0);
    idle(1);
    do_req(1'b0, 1'b0, 32'h44, 32'd0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 3, 2);

    // Tie after reset: fetch, data, fetch, data
    do_reset();
    resp_use_addr = 1'b1;
    resp_lat      = 0;
    for (int k = 0; k < 4; k++) begin
      e.is_d  = (k % 2 == 1);
      e.rdata = e.is_d ? (32'h200 ^ KEY) : (32'h100 ^ KEY);
      e.err   = 1'b0;
      sb.push_back(e);
    end
    if_req = 1'b1; if_addr = 32'h100;
    d_req  = 1'b1; d_addr  = 32'h200; d_we = 1'b0; d_wd = 32'd0;
    n_ack = 0; cyc = 0;
    while (n_ack < 4 && cyc < 30) begin
      @(posedge clock);
      #1;
      cyc++;
      if (if_ack || d_ack) n_ack++;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    check("tie_ack_count", n_ack, 32'd4);
    check("tie_last_ack_cycle", cyc, 32'd11);
    idle(3);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning memory address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum BUSY cycles to wait for mem_ack before aborting (range 1..255).
REQ-003 Port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous reset, active-high.
REQ-005 Port if_req  input  1  instruction-fetch request, level, held until if_ack.
REQ-006 Port if_addr  input  ADDR_W  fetch address, stable while if_req=1.
REQ-007 Port if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 Port if_rdata  output  32  fetched word, valid while if_ack=1.
REQ-009 Port d_req  input  1  data request, level, held until d_ack.
REQ-010 Port d_we  input  1  data write enable; 1 = store, 0 = load.
REQ-011 Port d_addr  input  ADDR_W  data address, stable while d_req=1.
REQ-012 Port d_wd  input  32  store data, stable while d_req=1.
REQ-013 Port d_ack  output  1  one-cycle data completion pulse.
REQ-014 Port d_rdata  output  32  load word, valid while d_ack=1.
REQ-015 Port mem_req  output  1  request to the shared single-port memory.
REQ-016 Port mem_we  output  1  memory write enable.
REQ-017 Port mem_addr  output  ADDR_W  memory address.
REQ-018 Port mem_wd  output  32  memory write data.
REQ-019 Port mem_rdata  input  32  memory read data, valid when mem_ack=1.
REQ-020 Port mem_ack  input  1  memory completion, any latency >= 0 cycles after mem_req rises.
REQ-021 Port bus_err  output  1  pulses with if_ack or d_ack when the transfer timed out.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-023 In IDLE with exactly one of if_req/d_req high, the block SHALL grant that requester, latch its address/we/wd into registers and go to BUSY.
REQ-024 In IDLE with both requests high, the block SHALL grant the requester not granted last (round-robin); the last-grant register SHALL reset to "data", so fetch wins the first tie.
REQ-025 A fetch grant SHALL drive mem_we=0 and mem_wd=0; a data grant SHALL drive mem_we=d_we and mem_wd=d_wd as latched.
REQ-026 mem_req, mem_we, mem_addr and mem_wd SHALL be registered, SHALL be valid for every cycle in BUSY, and mem_req SHALL be 0 in IDLE and RESP.
REQ-027 In BUSY, when mem_ack=1, the block SHALL capture mem_rdata into the granted requester's rdata register and go to RESP.
REQ-028 A BUSY cycle counter SHALL clear on entry to BUSY. If the counter reaches TIMEOUT with no mem_ack, the block SHALL go to RESP with rdata=0 and bus_err=1.
REQ-029 RESP SHALL last exactly one cycle. In it, only the granted requester's ack is 1, bus_err is 1 only after a timeout, and the next state is IDLE.
REQ-030 No grant SHALL occur in RESP. A requester still high in the following IDLE cycle SHALL be treated as a new request.
REQ-031 Minimum latency: request sampled in IDLE at cycle N, mem_req=1 at N+1, and with mem_ack at N+1 the ack is at N+2. Back-to-back grants are therefore at most one per 3 cycles.
REQ-032 mem_ack in IDLE or RESP SHALL be ignored.
REQ-033 if_rdata and d_rdata SHALL hold their last captured value when ack=0. For stores, d_rdata SHALL capture mem_rdata as-is.
REQ-034 if_ack and d_ack SHALL never be 1 in the same cycle.

Reset
REQ-035 While reset=1 at a clock edge, the block SHALL set: state=IDLE, last-grant=data, counter=0, mem_req=mem_we=0, mem_addr=mem_wd=0, if_ack=d_ack=bus_err=0, if_rdata=d_rdata=0.
REQ-036 Reset asserted in BUSY or RESP SHALL abort the transfer with no ack issued, and a later mem_ack SHALL be ignored.

Verification
REQ-037 Single fetch: if_req=1, if_addr=0x40, mem_ack one cycle after mem_req with rdata 0x2002000A -> mem_req cycle 1, if_ack=1 with if_rdata=0x2002000A at cycle 3, mem_we=0 throughout.
REQ-038 Tie: if_req=d_req=1 continuously after reset -> grant order fetch, data, fetch, data. d_ack is never in the same cycle as if_ack.
REQ-039 Store: d_req=1, d_we=1, d_addr=0x54, d_wd=7, mem_ack immediate -> mem_we=1, mem_addr=0x54, mem_wd=7 in BUSY, d_ack one cycle later.
REQ-040 Timeout: TIMEOUT=15, d_req=1, mem_ack never -> mem_req high exactly 15 cycles, then d_ack=1, bus_err=1, d_rdata=0, then IDLE.
REQ-041 Reset mid-BUSY: reset pulse in the 2nd BUSY cycle, then mem_ack -> mem_req=0 the cycle after reset, no ack, next request served normally.
